// File: rtl/p10_sprite_pkg.sv
// Shared constants, FSM encodings and the per-axis bounce step for the sprite scanner.
package p10_sprite_pkg;

    localparam int unsigned SCALE_SHIFT = 3;
    localparam int unsigned GRID_W      = 100;
    localparam int unsigned GRID_H      = 75;
    localparam int unsigned PIX_W       = 10;
    localparam int unsigned POS_W       = 7;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LOAD       = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             neg;
    } axis_t;

    // One frame of motion on one axis; a bound flips direction and steps the same cycle.
    function automatic axis_t axis_step(input axis_t a, input logic [POS_W-1:0] max_pos);
        axis_t r;
        r = a;
        if (!a.neg) begin
            if (a.pos >= max_pos) begin
                r.pos = a.pos - POS_W'(1);
                r.neg = 1'b1;
            end else begin
                r.pos = a.pos + POS_W'(1);
            end
        end else begin
            if (a.pos == '0) begin
                r.pos = a.pos + POS_W'(1);
                r.neg = 1'b0;
            end else begin
                r.pos = a.pos - POS_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/p10_sprite_bitmap.sv
// Sprite bitmap as one circular shift register: serial load has priority over rotation.
module p10_sprite_bitmap #(
    parameter int unsigned     N           = 64,
    parameter logic [N-1:0]    INIT_BITMAP = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic load,
    input  logic load_data,
    output logic data
);

    logic [N-1:0] bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            bits <= INIT_BITMAP;
        end else if (load) begin
            bits <= {bits[N-2:0], load_data};
        end else if (shift) begin
            bits <= {bits[N-2:0], bits[N-1]};
        end
    end

    assign data = bits[N-1];

endmodule

// File: rtl/p10_sprite_scan.sv
// Sprite scanner: pixel-to-grid decode, bounce motion, and reload FSM around the bitmap register.
module p10_sprite_scan
    import p10_sprite_pkg::*;
#(
    parameter int unsigned                  WIDTH       = 8,
    parameter int unsigned                  HEIGHT      = 8,
    parameter logic [WIDTH*HEIGHT-1:0]      INIT_BITMAP = '1,
    parameter int unsigned                  X0          = 0,
    parameter int unsigned                  Y0          = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  x_pix,
    input  logic [PIX_W-1:0]  y_pix,
    input  logic              display_on,
    input  logic              next_frame,
    input  logic              move_en,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_data,
    output logic              load_ready,
    output logic              load_busy,
    input  logic              sprite_shift,
    output logic              sprite_data,
    output logic              sprite_visible,
    output logic              sprite_access,
    output logic              new_line,
    output logic [POS_W-1:0]  sprite_x,
    output logic [POS_W-1:0]  sprite_y
);

    localparam int unsigned N     = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned CMP_W = POS_W + 1;
    localparam int unsigned X_MAX = GRID_W - WIDTH;
    localparam int unsigned Y_MAX = GRID_H - HEIGHT;
    localparam logic [POS_W-1:0] X_MAX_P = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_P = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_RST   = POS_W'((X0 > X_MAX) ? X_MAX : X0);
    localparam logic [POS_W-1:0] Y_RST   = POS_W'((Y0 > Y_MAX) ? Y_MAX : Y0);

    logic [1:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    axis_t            ax, ay, ax_next, ay_next;
    logic             accept;
    logic             idle;
    logic [POS_W-1:0] cx, cy;
    logic             in_x, in_y;

    assign idle   = (state == ST_IDLE);
    assign accept = (state == ST_LOAD) && load_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT_FRAME;
            cnt   <= '0;
            ax    <= '{pos: X_RST, neg: 1'b0};
            ay    <= '{pos: Y_RST, neg: 1'b0};
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ax    <= ax_next;
            ay    <= ay_next;
        end
    end

    // Reload sequencing; a next_frame coinciding with the last bit lands in WAIT_FRAME and is dropped.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                    cnt_next   = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state_next = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (next_frame) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_WAIT_FRAME;
        endcase
    end

    always_comb begin
        ax_next = ax;
        ay_next = ay;
        if (next_frame && move_en) begin
            ax_next = axis_step(ax, X_MAX_P);
            ay_next = axis_step(ay, Y_MAX_P);
        end
    end

    p10_sprite_bitmap #(
        .N           (N),
        .INIT_BITMAP (INIT_BITMAP)
    ) u_bitmap (
        .clk       (clk),
        .reset     (reset),
        .shift     (sprite_shift && idle),
        .load      (accept),
        .load_data (load_data),
        .data      (sprite_data)
    );

    assign cx   = x_pix[PIX_W-1:SCALE_SHIFT];
    assign cy   = y_pix[PIX_W-1:SCALE_SHIFT];
    assign in_x = ({1'b0, cx} >= {1'b0, ax.pos}) &&
                  ({1'b0, cx} <  ({1'b0, ax.pos} + CMP_W'(WIDTH)));
    assign in_y = ({1'b0, cy} >= {1'b0, ay.pos}) &&
                  ({1'b0, cy} <  ({1'b0, ay.pos} + CMP_W'(HEIGHT)));

    assign sprite_visible = display_on && idle && in_x && in_y;
    assign sprite_access  = display_on && (x_pix[SCALE_SHIFT-1:0] == '1);
    assign new_line       = (y_pix[SCALE_SHIFT-1:0] == '0);
    assign load_ready     = (state == ST_LOAD);
    assign load_busy      = !idle;
    assign sprite_x       = ax.pos;
    assign sprite_y       = ay.pos;

endmodule

// File: tb/tb_p10_sprite_scan.sv
// Directed + randomized bench for p10_sprite_scan against a queue-based behavioural model.
module tb_p10_sprite_scan;

    localparam logic [63:0] INIT_BM = 64'hF0E1_D2C3_B4A5_9687;
    localparam int XMAX = 92;
    localparam int YMAX = 67;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_WAIT = 2;

    logic       clk;
    logic       reset;
    logic [9:0] x_pix, y_pix;
    logic       display_on, next_frame, move_en;
    logic       load_start, load_valid, load_data;
    logic       load_ready, load_busy;
    logic       sprite_shift, sprite_data, sprite_visible, sprite_access, new_line;
    logic [6:0] sprite_x, sprite_y;

    int checks   = 0;
    int failures = 0;

    // behavioural model: bm[0] is the pixel currently presented (top-left after a full frame)
    bit bm[$];
    int mx, my, mdx, mdy, mst, mcnt;
    logic [63:0] init_v;

    p10_sprite_scan #(
        .WIDTH(8), .HEIGHT(8), .INIT_BITMAP(INIT_BM), .X0(10), .Y0(10)
    ) dut (
        .clk(clk), .reset(reset), .x_pix(x_pix), .y_pix(y_pix),
        .display_on(display_on), .next_frame(next_frame), .move_en(move_en),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_busy(load_busy), .sprite_shift(sprite_shift),
        .sprite_data(sprite_data), .sprite_visible(sprite_visible),
        .sprite_access(sprite_access), .new_line(new_line),
        .sprite_x(sprite_x), .sprite_y(sprite_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_bm();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63-i] = bm[i];
        return v;
    endfunction

    function automatic bit exp_vis();
        int cx, cy;
        cx = int'(x_pix) / 8;
        cy = int'(y_pix) / 8;
        return display_on && (mst == M_IDLE) && cx >= mx && cx < mx + 8 && cy >= my && cy < my + 8;
    endfunction

    task automatic model_reset();
        bm.delete();
        for (int i = 63; i >= 0; i--) bm.push_back(init_v[i]);
        mx = 10; my = 10; mdx = 1; mdy = 1; mst = M_WAIT; mcnt = 0;
    endtask

    // Advance the model with the inputs present at the coming edge, then step past it.
    task automatic tick();
        int nx, ny;
        if (reset) begin
            model_reset();
        end else begin
            if (mst == M_LOAD && load_valid) begin
                void'(bm.pop_front());
                bm.push_back(load_data);
                mcnt++;
            end else if (mst == M_IDLE && sprite_shift) begin
                bm.push_back(bm.pop_front());
            end
            if (next_frame && move_en) begin
                nx = mx + mdx;
                if (nx < 0 || nx > XMAX) begin mdx = -mdx; nx = mx + mdx; end
                ny = my + mdy;
                if (ny < 0 || ny > YMAX) begin mdy = -mdy; ny = my + mdy; end
                mx = nx; my = ny;
            end
            case (mst)
                M_IDLE: if (load_start) begin mst = M_LOAD; mcnt = 0; end
                M_LOAD: if (mcnt == 64) mst = M_WAIT;
                default: if (next_frame) mst = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb();
        #1;
        chk("visible", 64'(sprite_visible), 64'(exp_vis()));
        chk("access", 64'(sprite_access), 64'(display_on && (int'(x_pix) % 8 == 7)));
        chk("new_line", 64'(new_line), 64'(int'(y_pix) % 8 == 0));
        chk("data", 64'(sprite_data), 64'(bm[0]));
        chk("pos_x", 64'(sprite_x), 64'(mx));
        chk("pos_y", 64'(sprite_y), 64'(my));
        chk("ready", 64'(load_ready), 64'(mst == M_LOAD));
        chk("busy", 64'(load_busy), 64'(mst != M_IDLE));
    endtask

    initial begin
        int vis_cnt, sh_cnt, acc, cyc, seen92, r, c;
        logic [63:0] pat;
        init_v = INIT_BM;
        reset = 1'b1; x_pix = '0; y_pix = '0; display_on = 1'b0; next_frame = 1'b0;
        move_en = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 1'b0;
        sprite_shift = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;

        // reset state
        display_on = 1'b1; x_pix = 10'd80; y_pix = 10'd80;
        check_comb();
        chk("rst_bitmap", dut.u_bitmap.bits, init_v);
        chk("rst_busy", 64'(load_busy), 64'd1);
        chk("rst_visible", 64'(sprite_visible), 64'd0);
        for (int i = 0; i < 20; i++) begin
            x_pix = 10'($urandom_range(72, 151)); y_pix = 10'($urandom_range(72, 151));
            check_comb();
            tick();
        end

        // first frame: sprite at (10,10) with the line-stage shift model
        next_frame = 1'b1; tick(); next_frame = 1'b0;
        vis_cnt = 0; sh_cnt = 0;
        for (int y = 72; y < 152; y++) begin
            for (int x = 72; x < 152; x++) begin
                x_pix = 10'(x); y_pix = 10'(y);
                #1;
                sprite_shift = sprite_visible && sprite_access && new_line;
                if (sprite_visible) vis_cnt++;
                if (sprite_shift) sh_cnt++;
                if (sprite_shift && exp_vis()) begin
                    r = y / 8 - 10; c = x / 8 - 10;
                    chk("pix_data", 64'(sprite_data), 64'(init_v[63 - (r * 8 + c)]));
                end
                check_comb();
                tick();
            end
        end
        sprite_shift = 1'b0;
        chk("vis_count", 64'(vis_cnt), 64'd4096);
        chk("shift_count", 64'(sh_cnt), 64'd64);
        chk("frame_end_bitmap", dut.u_bitmap.bits, init_v);
        chk("frame_end_model", dut.u_bitmap.bits, pack_bm());

        // random probes with random rotation
        for (int i = 0; i < 300; i++) begin
            x_pix = 10'($urandom_range(0, 799)); y_pix = 10'($urandom_range(0, 599));
            display_on = 1'($urandom_range(0, 1));
            sprite_shift = 1'($urandom_range(0, 1));
            check_comb();
            tick();
        end
        sprite_shift = 1'b0;

        // motion with bounce at the right bound
        move_en = 1'b1; seen92 = -100;
        for (int f = 0; f < 90; f++) begin
            next_frame = 1'b1; tick(); next_frame = 1'b0;
            check_comb();
            if (f == seen92 + 1) chk("bounce_91", 64'(sprite_x), 64'd91);
            if (f == seen92 + 2) chk("bounce_90", 64'(sprite_x), 64'd90);
            if (mx == 92) seen92 = f;
            tick();
        end
        move_en = 1'b0;
        chk("bounce_seen", 64'(seen92 >= 0), 64'd1);

        // reload with alternating 1,0 during active video over the sprite
        display_on = 1'b1; x_pix = 10'(mx * 8 + 3); y_pix = 10'(my * 8 + 3);
        load_start = 1'b1; tick(); load_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 64 && cyc < 1000) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data = (acc % 2 == 0);
            load_start = (acc == 30);
            check_comb();
            if (load_ready && load_valid) acc++;
            tick(); cyc++;
        end
        load_start = 1'b0;
        chk("load_accepted", 64'(acc), 64'd64);
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin check_comb(); tick(); end
        load_valid = 1'b0;
        chk("after_load_ready", 64'(load_ready), 64'd0);
        chk("after_load_busy", 64'(load_busy), 64'd1);
        chk("reload_bitmap", dut.u_bitmap.bits, 64'hAAAA_AAAA_AAAA_AAAA);
        next_frame = 1'b1; tick(); next_frame = 1'b0;
        check_comb();
        chk("reload_idle", 64'(load_busy), 64'd0);
        chk("reload_data0", 64'(sprite_data), 64'd1);
        sprite_shift = 1'b1; tick(); sprite_shift = 1'b0;
        check_comb();
        chk("reload_data1", 64'(sprite_data), 64'd0);

        // reload of a random pattern with sprite_shift held high
        pat = {$urandom, $urandom};
        sprite_shift = 1'b1;
        load_start = 1'b1; tick(); load_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 64 && cyc < 1000) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data = pat[63 - acc];
            check_comb();
            if (load_ready && load_valid) acc++;
            tick(); cyc++;
        end
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin check_comb(); tick(); end
        sprite_shift = 1'b0;
        chk("forced_shift_pattern", dut.u_bitmap.bits, pat);

        // reset after 20 of 64 bits
        next_frame = 1'b1; tick(); next_frame = 1'b0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin load_data = 1'($urandom_range(0, 1)); tick(); end
        load_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check_comb();
        chk("midload_rst_bitmap", dut.u_bitmap.bits, init_v);
        chk("midload_rst_ready", 64'(load_ready), 64'd0);
        chk("midload_rst_busy", 64'(load_busy), 64'd1);

        // last bit coincides with next_frame
        next_frame = 1'b1; tick(); next_frame = 1'b0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        pat = {$urandom, $urandom};
        load_valid = 1'b1;
        for (int i = 0; i < 63; i++) begin load_data = pat[63 - i]; tick(); end
        load_data = pat[0]; next_frame = 1'b1; tick();
        next_frame = 1'b0; load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_comb();
            chk("coincide_wait", 64'(load_busy), 64'd1);
            tick();
        end
        next_frame = 1'b1; tick(); next_frame = 1'b0;
        check_comb();
        chk("coincide_idle", 64'(load_busy), 64'd0);
        chk("coincide_pattern", dut.u_bitmap.bits, pat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
